// File: rtl/ser_framer_tx.sv
// Byte-to-serial framing transmitter: one-deep holding buffer feeding a 16-bit
// MSB-first frame serialiser ({HEADER, data}) with an optional idle gap after each frame.
module ser_framer_tx #(
  parameter logic [7:0]  HEADER = 8'hA5,
  parameter int unsigned GAP    = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       clear_ovf,
  output logic       full,
  output logic       busy,
  output logic       data_out,
  output logic       overflow,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam logic [3:0] GapLast = 4'((GAP == 0) ? 0 : GAP - 1);
  localparam bit         NoGap   = (GAP == 0);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  hold_q;
  logic [14:0] shift_q;
  logic        frame_end;
  logic        xfer;

  assign frame_end = (state_q == StSend) && (cnt_q == 4'd15);

  // A transfer moves the held byte into the serialiser; it can only fire when full.
  always_comb begin
    xfer = 1'b0;
    unique case (state_q)
      StIdle:  xfer = full;
      StSend:  xfer = full && frame_end && NoGap;
      StGap:   xfer = full && (cnt_q == GapLast);
      default: xfer = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      data_out    <= 1'b0;
      busy        <= 1'b0;
      full        <= 1'b0;
      overflow    <= 1'b0;
      frames_sent <= 8'd0;
    end else begin
      // A rejected load outranks a clear at the same edge.
      if (load && full) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end

      if (xfer) begin
        full <= 1'b0;
      end else if (load && !full) begin
        full <= 1'b1;
      end

      if (frame_end) begin
        frames_sent <= frames_sent + 8'd1;
      end

      if (xfer) begin
        state_q  <= StSend;
        cnt_q    <= 4'd0;
        data_out <= HEADER[7];
        busy     <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            data_out <= 1'b0;
            busy     <= 1'b0;
          end
          StSend: begin
            if (frame_end) begin
              data_out <= 1'b0;
              cnt_q    <= 4'd0;
              if (!NoGap) begin
                state_q <= StGap;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              data_out <= shift_q[14];
              cnt_q    <= cnt_q + 4'd1;
            end
          end
          StGap: begin
            data_out <= 1'b0;
            if (cnt_q == GapLast) begin
              state_q <= StIdle;
              cnt_q   <= 4'd0;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: begin
            state_q  <= StIdle;
            data_out <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Data path registers carry no reset; HEADER[7] goes straight to data_out, the rest queues here.
  always_ff @(posedge clock) begin
    if (load && !full) begin
      hold_q <= data_in;
    end
    if (xfer) begin
      shift_q <= {HEADER[6:0], hold_q};
    end else if (state_q == StSend) begin
      shift_q <= {shift_q[13:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_ser_framer_tx.sv
// Self-checking bench for ser_framer_tx: table-driven single frame plus directed
// sequences for back-to-back, gap, overflow, mid-frame reset, loopback and wrap.
module tb_ser_framer_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       clear_ovf;

  logic       a_full, a_busy, a_dout, a_ovf;
  logic [7:0] a_frames;
  logic       b_full, b_busy, b_dout, b_ovf;
  logic [7:0] b_frames;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ser_framer_tx #(.HEADER(8'hA5), .GAP(0)) dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .load(load), .clear_ovf(clear_ovf),
    .full(a_full), .busy(a_busy), .data_out(a_dout), .overflow(a_ovf), .frames_sent(a_frames)
  );

  ser_framer_tx #(.HEADER(8'hA5), .GAP(3)) dut_b (
    .clock(clock), .reset(reset), .data_in(data_in), .load(load), .clear_ovf(clear_ovf),
    .full(b_full), .busy(b_busy), .data_out(b_dout), .overflow(b_ovf), .frames_sent(b_frames)
  );

  // Downstream receiver model: hunt for the header MSB (1), then take 16 bits.
  logic [15:0] rx_q[$];
  logic [15:0] rx_sr;
  int          rx_n;
  bit          rx_on;

  always @(negedge clock) begin
    if (reset) begin
      rx_on = 1'b0;
      rx_n  = 0;
    end else if (!rx_on) begin
      if (a_dout) begin
        rx_on = 1'b1;
        rx_sr = 16'd1;
        rx_n  = 1;
      end
    end else begin
      rx_sr = {rx_sr[14:0], a_dout};
      rx_n++;
      if (rx_n == 16) begin
        rx_q.push_back(rx_sr);
        rx_on = 1'b0;
      end
    end
  end

  typedef struct {
    logic       load;
    logic [7:0] data;
    logic       clr;
    logic       full;
    logic       busy;
    logic       dout;
    logic       ovf;
    logic [7:0] frames;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; clear_ovf = 1'b0; data_in = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    int n = 0;
    while (a_full && n < 100) begin
      tick();
      n++;
    end
    if (a_full) begin
      tests++; fails++;
      $display("FAIL load_wait: full stuck at 1, expected 0");
    end
    load = 1'b1; data_in = b;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || a_full) && n < 100) begin
      tick();
      n++;
    end
    if (a_busy || a_full) begin
      tests++; fails++;
      $display("FAIL idle_wait: busy=%0b full=%0b, expected both 0", a_busy, a_full);
    end
  endtask

  initial begin
    logic [15:0] exp_bits;
    logic [63:0] bits;
    logic [7:0]  rx;
    bit          flag;
    int          base;

    // Reset state
    do_reset();
    chk("rst_a", {a_full, a_busy, a_dout, a_ovf, a_frames}, 12'h000);
    chk("rst_b", {b_full, b_busy, b_dout, b_ovf, b_frames}, 12'h000);

    // Single frame of 8'h3C, GAP=0, cycle by cycle.
    exp_bits = 16'b1010_0101_0011_1100;
    for (int k = 0; k < 18; k++) vecs[k] = '{default: '0};
    vecs[0].load = 1'b1; vecs[0].data = 8'h3C; vecs[0].full = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      vecs[k].busy = 1'b1;
      vecs[k].dout = exp_bits[16-k];
    end
    vecs[17].frames = 8'd1;
    for (int k = 0; k < 18; k++) begin
      load = vecs[k].load; data_in = vecs[k].data; clear_ovf = vecs[k].clr;
      tick();
      chk($sformatf("vec%0d", k), {a_full, a_busy, a_dout, a_ovf, a_frames},
          {vecs[k].full, vecs[k].busy, vecs[k].dout, vecs[k].ovf, vecs[k].frames});
    end
    load = 1'b0;

    // Back-to-back frames, GAP=0.
    do_reset();
    load = 1'b1; data_in = 8'h11;
    tick();
    bits = '0;
    for (int k = 1; k <= 32; k++) begin
      load = (k == 3); data_in = 8'hF0;
      tick();
      bits = {bits[62:0], a_dout};
      if (k == 16) chk("b2b_full_pre", a_full, 1'b1);
      if (k == 17) chk("b2b_full_drop", a_full, 1'b0);
    end
    chk("b2b_bits", bits, {32'd0, 8'hA5, 8'h11, 8'hA5, 8'hF0});
    tick();
    chk("b2b_end", {a_busy, a_frames}, {1'b0, 8'd2});

    // GAP=3: exactly three busy zero bits between frames.
    do_reset();
    load = 1'b1; data_in = 8'h5A;
    tick();
    bits = '0; flag = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      load = (k == 2); data_in = 8'hC3;
      tick();
      bits = {bits[62:0], b_dout};
      flag = flag & b_busy;
    end
    chk("gap_bits", bits, {29'd0, 8'hA5, 8'h5A, 3'b000, 8'hA5, 8'hC3});
    chk("gap_busy", flag, 1'b1);

    // Overflow: third load while full is dropped.
    do_reset();
    load = 1'b1; data_in = 8'h55; tick();
    load = 1'b0; tick();
    load = 1'b1; data_in = 8'hAA; tick();
    load = 1'b1; data_in = 8'h77; tick();
    load = 1'b0;
    chk("ovf_set", {a_ovf, a_full}, 2'b11);
    rx = '0;
    for (int k = 4; k <= 33; k++) begin
      tick();
      if (k >= 25 && k <= 32) rx = {rx[6:0], a_dout};
    end
    chk("ovf_second_byte", rx, 8'hAA);
    chk("ovf_no_third", {a_busy, a_frames, a_ovf}, {1'b0, 8'd2, 1'b1});
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_clear", a_ovf, 1'b0);
    load = 1'b1; data_in = 8'h12; tick();
    load = 1'b1; data_in = 8'h34; clear_ovf = 1'b1; tick();
    load = 1'b0; clear_ovf = 1'b0;
    chk("ovf_set_wins", {a_ovf, a_full}, 2'b10);
    wait_idle();
    chk("ovf_frames", a_frames, 8'd3);

    // Reset mid-frame (bit 6) with a byte queued.
    do_reset();
    load = 1'b1; data_in = 8'h3C; tick();
    load = 1'b0; tick();
    load = 1'b1; data_in = 8'h99; tick();
    load = 1'b0;
    for (int k = 3; k <= 7; k++) tick();
    chk("mid_full_before", {a_full, a_busy}, 2'b11);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_after", {a_dout, a_busy, a_full, a_frames}, 11'd0);
    flag = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      flag = flag | a_busy | a_dout;
    end
    chk("mid_no_frame", flag, 1'b0);

    // Loopback into the receiver model.
    do_reset();
    base = rx_q.size();
    load_byte(8'h00);
    load_byte(8'hFF);
    load_byte(8'hA5);
    wait_idle();
    tick();
    chk("lb_count", rx_q.size() - base, 3);
    if (rx_q.size() - base == 3) begin
      chk("lb_00", rx_q[base], 16'hA500);
      chk("lb_ff", rx_q[base+1], 16'hA5FF);
      chk("lb_a5", rx_q[base+2], 16'hA5A5);
    end

    // frames_sent wrap.
    do_reset();
    for (int i = 0; i < 255; i++) load_byte(8'(i));
    wait_idle();
    chk("wrap_255", a_frames, 8'd255);
    load_byte(8'h42);
    wait_idle();
    chk("wrap_0", a_frames, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ser_framer_tx.md
Name: ser_framer_tx

Overview:
- Byte-to-serial framing transmitter; the stage directly upstream of the serial header/body receiver.
- Accepts parallel bytes through a one-deep holding buffer.
- Serialises each byte as a 16-bit frame, MSB first, one bit per clock: an 8-bit header (HEADER) followed by the 8 data bits.
- Inserts a configurable idle gap of zero bits between frames.
- Tracks dropped writes (overflow) and counts frames sent.

Parameters:
HEADER, 8'hA5, frame header pattern sent MSB first; must stay 8'hA5 to match the downstream receiver's hard-coded header
GAP, 0, number of idle (0) bit-times inserted after each frame; legal range 0..15

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
data_in  input  8  byte to transmit, sampled when load is accepted
load  input  1  write strobe for data_in, single-cycle per byte
clear_ovf  input  1  clears overflow sticky flag
full  output  1  holding buffer occupied; a load seen while full=1 is rejected
busy  output  1  serialiser active (frame bit or gap bit on data_out)
data_out  output  1  serial bit stream to receiver, registered
overflow  output  1  sticky: a load was rejected
frames_sent  output  8  count of completed frames, wraps 255->0

Behaviour:
- Reset values:
  - Reset (clock and reset already decided): reset reset, synchronous, active-high; clock clock.
  - Outputs: data_out=0, full=0, busy=0, overflow=0, frames_sent=0; state IDLE, bit counter 0.
  - Holding and shift data registers are not reset.
- Reset mid-frame aborts the frame. After the reset edge data_out=0 and full=0; the buffered byte is discarded; frames_sent is not incremented.
- Write accept:
  - At an edge with load=1 and full=0: hold<=data_in, full<=1.
  - load=1 with full=1 at the edge: byte dropped, overflow<=1. The decision uses full as sampled, even if a transfer empties the buffer at that same edge.
- overflow priority:
  - clear_ovf=1 clears overflow at the edge.
  - If clear_ovf and a rejected load occur at the same edge, overflow ends at 1 (set wins).
- States: IDLE, SEND (16 bit-times, 4-bit counter 0..15), GAP (GAP bit-times, counter 0..GAP-1).
- IDLE:
  - data_out=0, busy=0.
  - If full=1 at the edge: transfer. shift<={HEADER,hold}, full<=0, data_out<=HEADER[7], busy<=1, counter<=0, go to SEND.
- SEND:
  - Each edge shifts the next bit onto data_out: header bits 7..0, then data bits 7..0.
  - At the edge ending bit 15, frames_sent increments. Then:
    - GAP>0: go to GAP, data_out<=0, busy stays 1.
    - GAP=0 and full=1: perform the transfer directly (back-to-back, no idle bit).
    - Otherwise: go to IDLE, data_out<=0, busy<=0.
- GAP:
  - data_out=0, busy=1 for exactly GAP cycles.
  - At the edge ending the last gap cycle: if full=1, transfer directly to SEND; else go to IDLE.
- Latency and throughput:
  - Load accepted at edge E0 from IDLE: first header bit is valid on data_out after E1; last data bit is valid after E16.
  - Sustained period is 16+GAP cycles per byte.
- A load accepted at the same edge a transfer occurs is not possible (transfer needs full=1, so that load is rejected).
- A load accepted during SEND or GAP waits in hold. full=1 until that byte's transfer edge.
- frames_sent is 8-bit unsigned and wraps modulo 256.

Test Plan:
- Reset, GAP=0; single load of 8'h3C at E0 -> full=1 after E0, 0 after E1. data_out after E1..E16 = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. busy=1 over those 16 cycles, then 0. frames_sent=1.
- GAP=0; load 8'h11 then 8'hF0 while the first frame is sending -> the 32 bits of both frames are contiguous with no 0 between. frames_sent=2. full drops exactly at the second transfer edge.
- GAP=3; two queued bytes -> exactly 3 zero bits with busy=1 between frames. Second header MSB appears 19 cycles after the first.
- Load while full=1 (hold 8'h55, queued 8'hAA, third load 8'h77) -> 8'h77 never transmitted, overflow=1. clear_ovf pulse -> overflow=0. Clear and reject at the same edge -> overflow=1.
- Assert reset at bit 6 of a frame with a byte queued -> after that edge data_out=0, busy=0, full=0. frames_sent unchanged. No further frame until a new load.
- Loopback into the downstream receiver with bytes 8'h00, 8'hFF, 8'hA5 -> receiver data_out matches each byte, receiver ready sets once per frame. 256 frames -> frames_sent wraps to 0.
